// File: rtl/mult32_seq.sv
// Sequential 32x32 unsigned multiplier: one shared ripple adder iterated over 32 shift-add steps
// to build a 64-bit product, with a start/busy/done handshake.

module adder32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [32:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    logic p;
    assign p          = a_i[i] ^ b_i[i];
    assign sum_o[i]   = p ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & p);
  end

  assign cout_o = carry[32];

endmodule

module mult32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] mcand_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] product_q;

  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;
  logic [63:0] shifted;

  assign addend = acc_lo_q[0] ? mcand_q : 32'h0;

  adder32bit u_adder (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // 65-bit right shift of {cout, sum, acc_lo}; the dropped bit is the consumed multiplier bit.
  assign shifted = {cout, sum, acc_lo_q[31:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= 32'h0;
      acc_hi_q  <= 32'h0;
      acc_lo_q  <= 32'h0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 64'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= a;
            acc_hi_q <= 32'h0;
            acc_lo_q <= b;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          {acc_hi_q, acc_lo_q} <= shifted;
          cnt_q                <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            product_q <= shifted;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed cases with literal results plus a randomized soak,
// all compared every cycle against a transaction-level model built on a*b.

module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  wire         busy;
  wire         done;
  wire  [63:0] product;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mult32_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = idle, 1..32 = the 32 busy cycles, 33 = done cycle.
  int unsigned m_phase = 0;
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;
  logic [63:0] m_product = 64'h0;
  int          m_ops = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase   <= 0;
      m_product <= 64'h0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_a     <= a;
        m_b     <= b;
      end
    end else if (m_phase < 32) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == 32) begin
      m_phase   <= 33;
      m_product <= {32'h0, m_a} * {32'h0, m_b};
      m_ops     <= m_ops + 1;
    end else begin
      m_phase <= 0;
    end
  end

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check1("busy", {63'h0, busy}, {63'h0, (m_phase >= 1 && m_phase <= 32)});
        check1("done", {63'h0, done}, {63'h0, (m_phase == 33)});
        check1("product", product, m_product);
        check1("busy_and_done", {63'h0, busy & done}, 64'h0);
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] exp,
                        input string name, input bit poke);
    int lat;
    bit found;
    lat   = -1;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        lat   = i;
      end else if (poke) begin
        start = 1'($urandom % 2);
        a     = $urandom;
        b     = $urandom;
      end
    end
    start = 1'b0;
    if (found) begin
      check1(name, product, exp);
      check1({name, "_latency"}, 64'(lat), 64'd31);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no done pulse within 40 cycles, expected one after 32", name);
    end
  endtask

  initial begin
    int cnt;
    int cyc;
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check1("rst_product", product, 64'h0);
    check1("rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "mul_3x5", 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mul_max", 1'b0);

    // Back-to-back: start raised during DONE must be ignored.
    run_op(32'h0, 32'h1234_5678, 64'h0, "mul_zero_a", 1'b0);
    start = 1'b1;
    a     = 32'h1234_5678;
    b     = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check1("start_in_done_ignored", {63'h0, busy}, 64'h0);
    run_op(32'h1234_5678, 32'h0, 64'h0, "mul_zero_b", 1'b0);

    run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "mul_poke", 1'b1);

    // Abort mid-run with reset.
    run_op(32'd3, 32'd5, 64'hF, "mul_pre_abort", 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check1("abort_busy", {63'h0, busy}, 64'h0);
    check1("abort_product", product, 64'h0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check1("abort_no_done", 64'(cnt), 64'd0);
    run_op(32'd7, 32'd6, 64'h2A, "mul_7x6", 1'b0);

    // start and reset on the same edge: reset wins.
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    a     = 32'd5;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check1("reset_beats_start", {63'h0, busy}, 64'h0);
    @(negedge clk);
    check1("reset_beats_start_2", {63'h0, busy}, 64'h0);

    // Random soak until 1000 more operations complete.
    cnt = m_ops + 1000;
    cyc = 0;
    while (m_ops < cnt && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      reset = ($urandom % 1500) == 0;
      start = ($urandom % 4) != 0;
      case ($urandom % 8)
        0:       a = 32'h0;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom % 8)
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
    end
    reset = 1'b0;
    start = 1'b0;
    if (m_ops < cnt) begin
      n_vec++;
      n_err++;
      $display("FAIL soak: %0d operations completed, expected %0d", m_ops, cnt);
    end
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
